// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-channel pushbutton synchroniser, debouncer and press/release pulse generator
//
// Purpose:
//   Each raw button channel passes through a 2-flop synchroniser and is then
//   qualified by its own stable-time counter and 4-state FSM (IDLE,
//   PRESS_WAIT, PRESSED, RELEASE_WAIT). A new level is accepted only after it
//   has been seen for STABLE_CYCLES consecutive synchronised cycles.
//   The debounced level and single-cycle press/release strobes are all
//   registered.
//
// Optional feature (macro DEBOUNCE_AUTO_REPEAT_EN):
//   Adds a per-channel hold counter that, while PRESSED, re-issues
//   press_pulse after HOLD_CYCLES and then every REPEAT_CYCLES. Without the
//   macro the hold counters do not exist and there is exactly one
//   press_pulse per qualified press.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   btn_raw       in   [N_BTN] raw asynchronous button levels, 1 = pressed
//   btn_level     out  [N_BTN] debounced level
//   press_pulse   out  [N_BTN] 1-cycle strobe on qualified press (and repeats)
//   release_pulse out  [N_BTN] 1-cycle strobe on qualified release

module button_debouncer #(
  parameter int N_BTN         = 3,
  parameter int STABLE_CYCLES = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Parameter sanity: the repeat reload below assumes REPEAT_CYCLES <= HOLD_CYCLES.
  if (STABLE_CYCLES < 2 || REPEAT_CYCLES < 1 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_param_check
    $error("button_debouncer: illegal STABLE/HOLD/REPEAT parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CW-1:0]    cnt_q   [N_BTN];
  logic [CW-1:0]    cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam int            HW          = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  // After a repeat strobe the counter restarts REPEAT_CYCLES short of the
  // terminal value, so a single compare serves both first and later strobes.
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [HW-1:0] hold_q [N_BTN];
  logic [HW-1:0] hold_d [N_BTN];
`endif

  // Next-state logic: every channel is evaluated independently.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef DEBOUNCE_AUTO_REPEAT_EN
      hold_d[i]  = hold_q[i];   // held (frozen) unless PRESSED updates it
`endif
      unique case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            // Terminal compare comes before the increment, so cnt never wraps.
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
            hold_d[i]  = '0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = CNT_ONE;
          end
`ifdef DEBOUNCE_AUTO_REPEAT_EN
          else if (hold_q[i] == HOLD_LAST) begin
            press_d[i] = 1'b1;
            hold_d[i]  = HOLD_RELOAD;
          end else begin
            hold_d[i] = hold_q[i] + HW'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          if (sync2_q[i]) begin
            // Bounce back to PRESSED: no pulse, and the hold counter resumes
            // where it froze rather than restarting.
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = IDLE;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
        hold_q[i]  <= '0;
`endif
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef DEBOUNCE_AUTO_REPEAT_EN
        hold_q[i]  <= hold_d[i];
`endif
      end
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule
